bt_rx: RTL
==========

# bt_rx

UART receiver for the Bluetooth serial link: it recovers 8-bit bytes from the asynchronous `rx` line and presents each one with a single-cycle `valid` strobe. It sits directly downstream of the BT module's TX pin, mirroring the `BTt` transmitter on the return path. It consumes 8N1 frames, with optional even parity, at the same 50 MHz system clock.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- Derived `DIV = CLK_FREQ / (BAUD*16)`, integer truncation. Must be ≥ 1; the 16× oversampling tick fires once every `DIV` clocks.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  serial input, idles high, asynchronous to `clk`.
- `data_out`  out  8  last correctly received byte, LSB = first data bit.
- `valid`  out  1  one-cycle pulse; `data_out` is updated in the same cycle.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `parity_err`  out  1  one-cycle pulse on parity mismatch; constant 0 without the macro.
- `busy`  out  1  high while a frame is being received.

## Operation
- `rx` passes through a 2-FF synchronizer. Both flops reset to 1; all logic uses the synchronized value `rxs`.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP, WAIT_HIGH.
- IDLE:
  - Prescaler and tick counter are held at 0.
  - `rxs==0` moves to START and starts the prescaler.
- START: at tick 8 (mid start bit), sample `rxs`.
  - 1: glitch; return to IDLE with no output.
  - 0: clear the tick counter; go to DATA.
- DATA:
  - Every 16 ticks, sample `rxs` into the shift register, LSB first.
  - After the 8th bit, go to PARITY (macro) or STOP.
- PARITY: after 16 ticks, sample the parity bit; the check is computed at the stop sample.
- STOP: after 16 ticks, sample `rxs`.
  - 0: pulse `frame_err`; go to WAIT_HIGH.
  - 1 with parity mismatch: pulse `parity_err`; go to IDLE.
  - 1 otherwise: load `data_out`, pulse `valid`; go to IDLE.
- WAIT_HIGH (break/line-low): stay until `rxs==1`, then go to IDLE.
- Error precedence: `frame_err` over `parity_err`. On any error, `data_out` is unchanged and `valid` stays 0.
- `busy` = (state ≠ IDLE).
- Returning to IDLE at the stop midpoint allows back-to-back frames with no idle gap.

## Timing
- Reset values: `data_out`=0x00, `valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0, state IDLE.
- Reset is asynchronous. Asserting it mid-frame aborts the frame immediately, and no pulse is emitted on release.
- `rxs` lags `rx` by 2 clocks.
- Clock 0 = the cycle in which the FSM leaves IDLE.
  - Start-bit sample: clock 8·DIV.
  - Data bit k sample (k=0..7): clock (8+16·(k+1))·DIV.
  - Stop sample: clock 152·DIV (168·DIV with parity).
  - `valid`/error pulse in the cycle following the stop sample; `busy` falls in that same cycle.
- `valid`, `frame_err` and `parity_err` are each exactly 1 clock wide and mutually exclusive.
- A new start edge is accepted in the clock after the return to IDLE.

## Configuration
- `BT_RX_PARITY_EN` defined: 8E1 frames. The PARITY state is compiled in, even parity is checked over the 8 data bits, and `parity_err` is live.
- `BT_RX_PARITY_EN` undefined: 8N1 frames, no PARITY state, `parity_err` tied 0.

## Test plan
Bench settings: `CLK_FREQ`=50_000_000, `BAUD`=1_562_500 (DIV=2, 32 clk/bit).
- Reset low mid-frame, then released -> all outputs return to reset values; no pulse is emitted; the next valid frame 0x3C is received correctly.
- Send frame 0xAA, stop=1 -> one `valid` pulse at clock 305 after the start is detected; `data_out`=0xAA; `busy` falls in the same cycle.
- Start-bit glitch, `rx` low for 6 clocks -> return to IDLE; no `valid`/`frame_err`; `busy` high for 16 clocks only.
- 0x55 with stop bit held 0 for two bit times -> one `frame_err` pulse; `data_out` keeps its previous value; `busy` stays high until `rx` returns high.
- Back-to-back 0x01, 0xFF, 0x80 with no idle gap -> three `valid` pulses, 320 clocks apart, with the correct bytes.
- With `BT_RX_PARITY_EN`: 0x07 with parity=0 -> `parity_err` pulse, no `valid`; 0x07 with parity=1 -> `valid`, `data_out`=0x07.

Source files
------------

// File: rtl/bt_rx.sv
// bt_rx: 16x-oversampled UART receiver, 8N1 by default or 8E1 when BT_RX_PARITY_EN is defined.
// Each byte is presented with a one-cycle valid strobe; framing and parity faults pulse their own flags.
module bt_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef BT_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t         state_q, state_d;
    logic           sync1_q, rxs_q;
    logic [PW-1:0]  presc_q, presc_d;
    logic [3:0]     tick_q, tick_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           ferr_q, ferr_d;
    logic           tick;
    logic           parity_bad;
`ifdef BT_RX_PARITY_EN
    logic           par_q, par_d;
    logic           perr_q, perr_d;
`endif

    assign tick = (presc_q == PW'(DIV - 1));

`ifdef BT_RX_PARITY_EN
    // Even parity: data bits plus parity bit must hold an even number of ones.
    assign parity_bad = ^{shift_q, par_q};
`else
    assign parity_bad = 1'b0;
`endif

    // NOTE: every next-state signal gets its default before the case statement, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef BT_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif

        if (state_q != S_IDLE) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                tick_d = tick_q + 4'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                presc_d = '0;
                tick_d  = '0;
                bit_d   = '0;
                if (!rxs_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick && tick_q == 4'd7) begin
                    if (rxs_q) begin
                        state_d = S_IDLE;
                    end else begin
                        tick_d  = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick && tick_q == 4'd15) begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef BT_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef BT_RX_PARITY_EN
            S_PARITY: begin
                if (tick && tick_q == 4'd15) begin
                    par_d   = rxs_q;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick && tick_q == 4'd15) begin
                    if (!rxs_q) begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end else if (parity_bad) begin
`ifdef BT_RX_PARITY_EN
                        perr_d  = 1'b1;
`endif
                        state_d = S_IDLE;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_HIGH: begin
                // Line held low past the stop bit: wait for it to recover before hunting a new start.
                presc_d = '0;
                tick_d  = '0;
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            state_q <= S_IDLE;
            presc_q <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef BT_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            sync1_q <= rx;
            rxs_q   <= sync1_q;
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef BT_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);
`ifdef BT_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
